// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned 32x32 multiply (shift-add) and restoring divide (one bit per cycle).
module alu_multicycle (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  ALUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_MULT = 4'b1111;
    localparam logic [3:0] OP_DIV  = 4'b0011;

    logic [1:0]  state;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [5:0]  count;
    logic [5:0]  count_next;
    // Shared iteration register: {partial product, multiplier} for MUL,
    // {remainder, dividend/quotient} for DIV.
    logic [63:0] acc;
    logic [63:0] iter_next;
    logic [31:0] single_res;

    logic [32:0] mul_sum;
    logic [31:0] rem;
    logic        bit_in;
    logic        div_ge;
    logic [31:0] div_diff;

    always_comb begin
        single_res = 32'd0;
        case (ALUCtrl)
            OP_AND:  single_res = A & B;
            OP_OR:   single_res = A | B;
            OP_ADD:  single_res = A + B;
            OP_SUB:  single_res = A - B;
            OP_SLT:  single_res = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            OP_SLL:  single_res = B << shamt;
            OP_SRL:  single_res = B >> shamt;
            OP_NOT:  single_res = ~A;
            default: single_res = 32'd0;
        endcase
    end

    // A zero divisor always passes the trial compare, giving an all-ones
    // quotient and leaving the dividend in the remainder.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, a_q};
        rem       = acc[63:32];
        bit_in    = acc[31];
        div_ge    = {rem, bit_in} >= {1'b0, b_q};
        div_diff  = {rem[30:0], bit_in} - b_q;
        iter_next = acc;
        if (state == MUL) begin
            if (acc[0]) begin
                iter_next = {mul_sum, acc[31:1]};
            end else begin
                iter_next = {1'b0, acc[63:1]};
            end
        end else if (state == DIV) begin
            if (div_ge) begin
                iter_next = {div_diff, acc[30:0], 1'b1};
            end else begin
                iter_next = {rem[30:0], bit_in, acc[30:0], 1'b0};
            end
        end
    end

    assign count_next = count + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            count  <= 6'd0;
            acc    <= 64'd0;
            result <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        count <= 6'd0;
                        if (ALUCtrl == OP_MULT) begin
                            acc   <= {32'd0, B};
                            busy  <= 1'b1;
                            state <= MUL;
                        end else if (ALUCtrl == OP_DIV) begin
                            acc   <= {32'd0, A};
                            busy  <= 1'b1;
                            state <= DIV;
                        end else begin
                            result <= single_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL, DIV: begin
                    acc   <= iter_next;
                    count <= count_next;
                    if (count_next == 6'd32) begin
                        hi     <= iter_next[63:32];
                        lo     <= iter_next[31:0];
                        result <= iter_next[31:0];
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign zero = (result == 32'd0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed scoreboard bench for alu_multicycle: expected results are queued at
// issue time from a behavioural model and compared when done pulses.
module tb_alu_multicycle;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ALUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    alu_multicycle dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ALUCtrl (ALUCtrl),
        .A       (A),
        .B       (B),
        .shamt   (shamt),
        .result  (result),
        .zero    (zero),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        logic [63:0] p;
        e.hi  = model_hi;
        e.lo  = model_lo;
        e.res = 32'd0;
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: e.res = b << sh;
            4'b1000: e.res = b >> sh;
            4'b1001: e.res = ~a;
            4'b1111: begin
                p     = {32'd0, a} * {32'd0, b};
                e.hi  = p[63:32];
                e.lo  = p[31:0];
                e.res = p[31:0];
            end
            4'b0011: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.hi = a % b;
                    e.lo = a / b;
                end
                e.res = e.lo;
            end
            default: e.res = 32'd0;
        endcase
        return e;
    endfunction

    // Issue one op from IDLE/DONE, track latency and busy, then score the result.
    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] sh,
                                  input bit poke);
        exp_t e;
        exp_t got;
        int   cycles;
        int   busy_cnt;
        bit   multi;
        multi = (op == 4'b1111) || (op == 4'b0011);
        e = model(op, a, b, sh);
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        ALUCtrl = op;
        A       = a;
        B       = b;
        shamt   = sh;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cycles   = 1;
        busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (poke && cycles == 5) begin
                start   = 1'b1;
                ALUCtrl = 4'b0010;
                A       = 32'h0000_1234;
                B       = 32'h0000_0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_output("latency", cycles, multi ? 32'd33 : 32'd1);
        check_output("busy_cycles", busy_cnt, multi ? 32'd32 : 32'd0);
        check_output("busy_at_done", {31'd0, busy}, 32'd0);
        check_output("done_high", {31'd0, done}, 32'd1);
        got = sb.pop_front();
        check_output("result", result, got.res);
        check_output("hi", hi, got.hi);
        check_output("lo", lo, got.lo);
        check_output("zero", {31'd0, zero}, {31'd0, (got.res == 32'd0)});
        @(negedge clk);
        check_output("done_pulse_width", {31'd0, done}, 32'd0);
    endtask

    initial begin
        exp_t e;
        exp_t got;
        total    = 0;
        bad      = 0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        ALUCtrl  = 4'd0;
        A        = 32'd0;
        B        = 32'd0;
        shamt    = 5'd0;

        #3;
        check_output("reset_result", result, 32'd0);
        check_output("reset_hi", hi, 32'd0);
        check_output("reset_lo", lo, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(4'b0010, 32'd7, 32'd5, 5'd0, 1'b0);
        apply_stimulus(4'b0110, 32'd5, 32'd5, 5'd0, 1'b0);
        apply_stimulus(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        apply_stimulus(4'b0111, 32'd1, 32'hFFFF_FFFF, 5'd0, 1'b0);
        apply_stimulus(4'b0101, 32'd0, 32'd1, 5'd31, 1'b0);
        apply_stimulus(4'b1000, 32'd0, 32'h8000_0000, 5'd31, 1'b0);
        apply_stimulus(4'b0000, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, 1'b0);
        apply_stimulus(4'b0001, 32'hF000_0000, 32'h0000_000F, 5'd0, 1'b0);
        apply_stimulus(4'b1001, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
        apply_stimulus(4'b0100, 32'hDEAD_BEEF, 32'h1, 5'd3, 1'b0);

        apply_stimulus(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1);
        apply_stimulus(4'b0010, 32'h0000_0100, 32'h0000_0023, 5'd0, 1'b0);
        apply_stimulus(4'b1111, 32'h0001_2345, 32'h0000_BEEF, 5'd0, 1'b0);
        apply_stimulus(4'b0011, 32'd100, 32'd7, 5'd0, 1'b0);
        apply_stimulus(4'b0011, 32'hFFFF_FFF0, 32'h0000_1001, 5'd0, 1'b0);
        apply_stimulus(4'b0011, 32'd9, 32'd0, 5'd0, 1'b0);

        // Back-to-back: a new start presented while in DONE is taken with no bubble.
        e = model(4'b0010, 32'd40, 32'd2, 5'd0);
        sb.push_back(e);
        ALUCtrl = 4'b0010; A = 32'd40; B = 32'd2; start = 1'b1;
        @(negedge clk);
        check_output("b2b_first_done", {31'd0, done}, 32'd1);
        got = sb.pop_front();
        check_output("b2b_first_result", result, got.res);
        e = model(4'b0110, 32'd3, 32'd10, 5'd0);
        sb.push_back(e);
        ALUCtrl = 4'b0110; A = 32'd3; B = 32'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("b2b_second_done", {31'd0, done}, 32'd1);
        got = sb.pop_front();
        check_output("b2b_second_result", result, got.res);
        check_output("b2b_hi_held", hi, got.hi);
        check_output("b2b_lo_held", lo, got.lo);
        @(negedge clk);

        // Asynchronous reset mid-MULT, away from any clock edge.
        ALUCtrl = 4'b1111; A = 32'd3; B = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_output("abort_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("abort_result", result, 32'd0);
        check_output("abort_hi", hi, 32'd0);
        check_output("abort_lo", lo, 32'd0);
        check_output("abort_busy", {31'd0, busy}, 32'd0);
        check_output("abort_done", {31'd0, done}, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("abort_no_done", {31'd0, done}, 32'd0);
        end
        apply_stimulus(4'b0010, 32'd2, 32'd3, 5'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
